cla_nibble_seq_adder: RTL and testbench
=======================================

// Module: cla_nibble_seq_adder
// PURPOSE
//  Sequencer that performs a WIDTH-bit addition by reusing one 4-bit CLA
//  instance (bit_4) once per nibble, LSB nibble first, with the carry
//  registered between nibbles. It sits between a requester and the shared
//  4-bit CLA datapath, trading latency for area. Valid/ready handshake on
//  both the operand and the result side.
// PARAMETERS
//  WIDTH    16  operand/sum width in bits; must be a multiple of 4 and >= 4
//               (elaboration error otherwise)
//  NIBBLES  WIDTH/4 (localparam) number of CLA passes per operation
// PORTS
//  clk        in   1      system clock, all state on posedge
//  rst        in   1      synchronous reset, ACTIVE-LOW (0 = reset)
//  in_valid   in   1      operands A, B, cin valid
//  in_ready   out  1      block can accept operands (IDLE only)
//  A          in   WIDTH  operand A, sampled on accept
//  B          in   WIDTH  operand B, sampled on accept
//  cin        in   1      carry-in, sampled on accept
//  out_valid  out  1      S/cout hold a completed result
//  out_ready  in   1      consumer takes result
//  S          out  WIDTH  sum, registered
//  cout       out  1      carry-out of MSB nibble, registered
//  busy       out  1      1 in RUN state
// BEHAVIOUR
//  - One clock; reset synchronous, active-low: on posedge clk with rst==0 ->
//    state=IDLE, S=0, cout=0, out_valid=0, busy=0, nibble idx=0, carry=0,
//    operand regs=0. Reset mid-operation aborts; no result is produced.
//  - in_ready = (state==IDLE) && rst; combinational from state only.
//  - FSM: IDLE -> RUN on in_valid&&in_ready (latch A,B; carry<=cin; idx<=0;
//    S<=0). RUN: each cycle feed A[idx*4+:4], B[idx*4+:4], carry to bit_4;
//    S[idx*4+:4]<=sum, carry<=nibble cout, idx<=idx+1. On idx==NIBBLES-1
//    also cout<=nibble cout, go DONE. DONE: out_valid=1; -> IDLE on
//    out_ready (same edge clears out_valid).
//  - Latency: out_valid rises NIBBLES cycles after the accept edge
//    (WIDTH=16: accept at edge 0, out_valid high after edge 4).
//  - S/cout stable and out_valid held while DONE && !out_ready (backpressure);
//    in_ready stays 0 until result consumed. No new accept in DONE cycle;
//    earliest next accept is the cycle after out_ready handshake.
//  - In RUN/DONE, changes on A, B, cin, in_valid are ignored.
//  - idx width = clog2(NIBBLES) (min 1); must not wrap before DONE.
//  - Result equals {cout,S} = A + B + cin exactly (mod 2^(WIDTH+1)).
//  - out_ready while not DONE is ignored.
// CONFIGURATION
//  OVF_FLAG_EN defined: extra output port `ovf` (out, 1): two's-complement
//    overflow = carry into MSB XOR cout, computed on the final nibble,
//    registered with cout, reset to 0, held through DONE like S.
//  OVF_FLAG_EN undefined: no `ovf` port, no overflow logic.
// TESTING (WIDTH=16)
//  A=16'h00FF,B=16'h0001,cin=0 -> S=16'h0100,cout=0; out_valid 4 clk after accept
//  A=16'hFFFF,B=16'h0001,cin=0 -> S=16'h0000,cout=1 (carry through all nibbles)
//  A=16'h0000,B=16'hFFFF,cin=1 -> S=16'h0000,cout=1; then A=16'h1234,B=16'h4321,
//    cin=0 back-to-back -> S=16'h5555,cout=0
//  out_ready=0 for 3 clk in DONE -> S,cout,out_valid unchanged, in_ready=0;
//    out_ready=1 -> in_ready=1 next clk
//  rst=0 at RUN idx=2 -> next clk IDLE, S=0, cout=0, out_valid=0, in_ready=1
//  OVF_FLAG_EN: A=16'h7FFF,B=16'h0001 -> S=16'h8000,ovf=1; 16'hFFFF+1 -> ovf=0

Source files
------------

// File: rtl/cla_nibble_seq_adder_if.sv
// Operand/result handshake bundle for cla_nibble_seq_adder.
// Defining OVF_FLAG_EN adds the registered two's-complement overflow flag `ovf`.
interface cla_nibble_seq_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             cout;
    logic             busy;
`ifdef OVF_FLAG_EN
    logic             ovf;

    modport master (
        output in_valid, A, B, cin, out_ready,
        input  in_ready, out_valid, S, cout, busy, ovf
    );

    modport slave (
        input  in_valid, A, B, cin, out_ready,
        output in_ready, out_valid, S, cout, busy, ovf
    );
`else
    modport master (
        output in_valid, A, B, cin, out_ready,
        input  in_ready, out_valid, S, cout, busy
    );

    modport slave (
        input  in_valid, A, B, cin, out_ready,
        output in_ready, out_valid, S, cout, busy
    );
`endif
endinterface

// File: rtl/cla_nibble_seq_adder.sv
// WIDTH-bit adder that reuses one 4-bit carry-lookahead cell (bit_4) once per nibble, LSB first.
// Optional feature macro: OVF_FLAG_EN (adds registered two's-complement overflow output).
module bit_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of generate/propagate products; no ripple chain.
    assign c[0]  = c_in;
    assign c[1]  = g[0] | (p[0] & c_in);
    assign c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & c_in);
    assign c_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & c_in);

    assign sum = p ^ c;
endmodule

module cla_nibble_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cla_nibble_seq_adder_if.slave bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("cla_nibble_seq_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] s_reg;
    logic             cout_reg;
    logic             ready_int;
    logic             accept;
    logic             last;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       nib_sum;
    logic             nib_cout;

    assign last   = (idx == IDX_W'(NIBBLES - 1));
    assign accept = bus.in_valid && ready_int;

    assign a_nib = a_reg[4*int'(idx) +: 4];
    assign b_nib = b_reg[4*int'(idx) +: 4];

    bit_4 u_cla (
        .a     (a_nib),
        .b     (b_nib),
        .c_in  (carry),
        .sum   (nib_sum),
        .c_out (nib_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // in_ready depends only on state and reset so a requester never sees a combinational path from in_valid.
    always_comb begin
        state_nxt     = state;
        ready_int     = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            IDLE: begin
                ready_int = rst;
                if (bus.in_valid && rst) state_nxt = RUN;
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        bus.in_ready = ready_int;
    end

`ifdef OVF_FLAG_EN
    logic ovf_reg;
    logic c_msb;

    // Carry into the MSB is recovered from the top sum bit: s3 = a3 ^ b3 ^ c3.
    assign c_msb   = a_nib[3] ^ b_nib[3] ^ nib_sum[3];
    assign bus.ovf = ovf_reg;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            s_reg    <= '0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
            idx      <= '0;
`ifdef OVF_FLAG_EN
            ovf_reg  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg <= bus.A;
                        b_reg <= bus.B;
                        carry <= bus.cin;
                        idx   <= '0;
                        s_reg <= '0;
                    end
                end
                RUN: begin
                    s_reg[4*int'(idx) +: 4] <= nib_sum;
                    carry                   <= nib_cout;
                    if (last) begin
                        idx      <= '0;
                        cout_reg <= nib_cout;
`ifdef OVF_FLAG_EN
                        ovf_reg  <= c_msb ^ nib_cout;
`endif
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.S    = s_reg;
    assign bus.cout = cout_reg;
endmodule

// File: tb/tb_cla_nibble_seq_adder.sv
// Directed bench for cla_nibble_seq_adder (WIDTH=16); expected sums are hand-computed.
module tb_cla_nibble_seq_adder;
    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    cla_nibble_seq_adder_if #(.WIDTH(WIDTH)) bus ();

    cla_nibble_seq_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic c, input string tag);
        int n;
        n = 0;
        while (!bus.in_ready && n < 10) begin
            step();
            n++;
        end
        check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.B        = b;
        bus.cin      = c;
        step();
        bus.in_valid = 1'b0;
        bus.A        = 16'hDEAD;
        bus.B        = 16'hBEEF;
        bus.cin      = ~c;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(NIBBLES));
    endtask

    task automatic finish_op(input logic [15:0] exp_s, input logic exp_c, input string tag);
        check({tag, "_s"}, 32'(bus.S), 32'(exp_s));
        check({tag, "_cout"}, 32'(bus.cout), 32'(exp_c));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, "_vld_clr"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_rdy_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
        rst           = 1'b0;
        step();
        step();
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_s", 32'(bus.S), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        rst = 1'b1;
        #1;
        check("rel_in_ready", 32'(bus.in_ready), 32'd1);

        start_op(16'h00FF, 16'h0001, 1'b0, "v1");
        finish_op(16'h0100, 1'b0, "v1");

        start_op(16'hFFFF, 16'h0001, 1'b0, "v2");
`ifdef OVF_FLAG_EN
        check("v2_ovf", 32'(bus.ovf), 32'd0);
`endif
        finish_op(16'h0000, 1'b1, "v2");

        start_op(16'h0000, 16'hFFFF, 1'b1, "v3");
        finish_op(16'h0000, 1'b1, "v3");
        start_op(16'h1234, 16'h4321, 1'b0, "v4");
        finish_op(16'h5555, 1'b0, "v4");

        start_op(16'h8000, 16'h8000, 1'b1, "v5");
`ifdef OVF_FLAG_EN
        check("v5_ovf", 32'(bus.ovf), 32'd1);
`endif
        finish_op(16'h0001, 1'b1, "v5");

        start_op(16'h7FFF, 16'h0001, 1'b0, "v6");
`ifdef OVF_FLAG_EN
        check("v6_ovf", 32'(bus.ovf), 32'd1);
`endif
        finish_op(16'h8000, 1'b0, "v6");

        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("idle_oready_rdy", 32'(bus.in_ready), 32'd1);
        check("idle_oready_vld", 32'(bus.out_valid), 32'd0);

        start_op(16'hF0F0, 16'h1010, 1'b0, "bp");
        bus.in_valid = 1'b1;
        bus.A        = 16'h0000;
        bus.B        = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_s", 32'(bus.S), 32'h0100);
            check("bp_hold_cout", 32'(bus.cout), 32'd1);
            check("bp_hold_vld", 32'(bus.out_valid), 32'd1);
            check("bp_hold_rdy", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("bp_rdy_after", 32'(bus.in_ready), 32'd1);
        check("bp_s_kept", 32'(bus.S), 32'h0100);

        bus.in_valid = 1'b1;
        bus.A        = 16'h1111;
        bus.B        = 16'h2222;
        bus.cin      = 1'b0;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        check("mid_s_partial", 32'(bus.S), 32'h0033);
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_s", 32'(bus.S), 32'd0);
        check("mid_rst_cout", 32'(bus.cout), 32'd0);
        check("mid_rst_vld", 32'(bus.out_valid), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_rdy", 32'(bus.in_ready), 32'd1);
        step();
        step();
        check("mid_rst_no_result", 32'(bus.out_valid), 32'd0);

        start_op(16'hABCD, 16'h1111, 1'b1, "v7");
        finish_op(16'hBCDF, 1'b0, "v7");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
